// File: rtl/float_alu_pipe.sv
// Two-stage pipelined mini-float ALU (add, sub, mul, min, max) with valid/ready on both sides.
// Arithmetic truncates toward zero, saturates on overflow and flushes to +0 on underflow.
module float_alu_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [3:0]           op,
  input  logic [TAG_W-1:0]     tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic [TAG_W-1:0]     out_tag,
  output logic [2:0]           out_flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int EMAX = 2**EXP_W - 1;
  localparam int SW   = MAN_W + 1;
  localparam int F    = SW + 3;
  localparam int PA   = F - 1;
  localparam int PM   = 2 * MAN_W;
  localparam int P    = (PA > PM) ? PA : PM;
  localparam int RW   = P + 2;
  localparam int XW   = EXP_W + 8;

  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MIN = 4'b0100;
  localparam logic [3:0] OP_MAX = 4'b0101;

  typedef enum logic [1:0] {K_ADD, K_MUL, K_PASS, K_INV} kind_e;

  function automatic logic signed [XW-1:0] ext_exp(input logic [EXP_W-1:0] e);
    return $signed({8'b0, e});
  endfunction

  // Signed numeric key so that min/max reduce to a plain signed compare; +0 and -0 collide.
  function automatic logic signed [W:0] to_key(input logic s, input logic [W-2:0] mag);
    logic signed [W:0] k;
    k = $signed({2'b00, mag});
    return s ? -k : k;
  endfunction

  // Right-shift the smaller significand, keeping guard/round bits and OR-ing everything
  // shifted further out into a sticky LSB so a following subtraction borrows correctly.
  function automatic logic [F-1:0] align_sig(input logic [SW-1:0] sig, input logic [EXP_W-1:0] d);
    logic [F-1:0] ext;
    logic [F-1:0] mask;
    logic [F-1:0] res;
    ext  = {sig, 3'b000};
    mask = ~({F{1'b1}} << d);
    if (int'(d) >= F) res = {{(F-1){1'b0}}, |sig};
    else              res = (ext >> d) | {{(F-1){1'b0}}, |(ext & mask)};
    return res;
  endfunction

  // Normalise, truncate, saturate/flush and pack; returns {flags, y}.
  function automatic logic [W+2:0] pack_result(input kind_e kind, input logic sign,
                                               input logic signed [XW-1:0] e,
                                               input logic [RW-1:0] m,
                                               input logic [W-1:0] pass);
    logic [W+2:0]         res;
    logic [RW-1:0]        norm;
    logic signed [XW-1:0] er;
    int                   lead;
    lead = 0;
    for (int i = 0; i < RW; i++) if (m[i]) lead = i;
    norm = m << (RW - 1 - lead);
    er   = e + XW'(lead - P);
    if (kind == K_INV)       res = {3'b100, {W{1'b0}}};
    else if (kind == K_PASS) res = {3'b000, pass};
    else if (m == '0)        res = {3'b000, (kind == K_MUL) && sign, {(W-1){1'b0}}};
    else if (er > EMAX_X)    res = {3'b010, sign, {(W-1){1'b1}}};
    else if (er < ONE_X)     res = {3'b001, {W{1'b0}}};
    else                     res = {3'b000, sign, er[EXP_W-1:0], norm[RW-2 -: MAN_W]};
    return res;
  endfunction

  logic                 sa, sb, sb_eff, za, zb, a_big, eff_sub;
  logic [EXP_W-1:0]     ea, eb, ea_z, eb_z, e_l, e_s;
  logic [MAN_W-1:0]     ma, mb;
  logic [W-2:0]         mag_a, mag_b;
  logic [SW-1:0]        sig_a, sig_b, sig_l, sig_s;
  logic [F-1:0]         sig_s_al;
  logic [F:0]           sum;
  logic [2*SW-1:0]      prod;
  logic signed [W:0]    key_a, key_b;

  kind_e                kind_d;
  logic                 sign_d;
  logic signed [XW-1:0] exp_d;
  logic [RW-1:0]        mag_d;
  logic [W-1:0]         pass_d;

  always_comb begin
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    za       = (ea == '0);
    zb       = (eb == '0);
    ea_z     = za ? '0 : ea;
    eb_z     = zb ? '0 : eb;
    mag_a    = za ? '0 : {ea, ma};
    mag_b    = zb ? '0 : {eb, mb};
    sig_a    = za ? '0 : {1'b1, ma};
    sig_b    = zb ? '0 : {1'b1, mb};
    sb_eff   = sb ^ (op == OP_SUB);
    a_big    = (mag_a >= mag_b);
    sig_l    = a_big ? sig_a : sig_b;
    sig_s    = a_big ? sig_b : sig_a;
    e_l      = a_big ? ea_z : eb_z;
    e_s      = a_big ? eb_z : ea_z;
    eff_sub  = sa ^ sb_eff;
    sig_s_al = align_sig(sig_s, e_l - e_s);
    sum      = eff_sub ? ({1'b0, sig_l, 3'b000} - {1'b0, sig_s_al})
                       : ({1'b0, sig_l, 3'b000} + {1'b0, sig_s_al});
    prod     = {{SW{1'b0}}, sig_a} * {{SW{1'b0}}, sig_b};
    key_a    = to_key(sa, mag_a);
    key_b    = to_key(sb, mag_b);

    kind_d = K_INV;
    sign_d = 1'b0;
    exp_d  = '0;
    mag_d  = '0;
    pass_d = '0;
    // Sums and products share one magnitude register with the hidden-bit weight at index P.
    case (op)
      OP_ADD, OP_SUB: begin
        kind_d      = K_ADD;
        sign_d      = a_big ? sa : sb_eff;
        exp_d       = ext_exp(e_l);
        mag_d[F:0]  = sum;
        mag_d       = mag_d << (P - PA);
      end
      OP_MUL: begin
        kind_d            = K_MUL;
        sign_d            = sa ^ sb;
        exp_d             = ext_exp(ea_z) + ext_exp(eb_z) - BIAS_X;
        mag_d[2*SW-1:0]   = prod;
        mag_d             = mag_d << (P - PM);
      end
      OP_MIN: begin
        kind_d = K_PASS;
        pass_d = (key_b < key_a) ? b : a;
      end
      OP_MAX: begin
        kind_d = K_PASS;
        pass_d = (key_b > key_a) ? b : a;
      end
      default: ;
    endcase
  end

  logic                 vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic                 s2_ready, load_p1, load_p2;
  kind_e                kind_p1_q;
  logic                 sign_p1_q;
  logic signed [XW-1:0] exp_p1_q;
  logic [RW-1:0]        mag_p1_q;
  logic [W-1:0]         pass_p1_q;
  logic [TAG_W-1:0]     tag_p1_q;
  logic [W-1:0]         y_p2_q;
  logic [TAG_W-1:0]     tag_p2_q;
  logic [2:0]           flags_p2_q;
  logic [W+2:0]         res_p2_d;

  always_comb begin
    s2_ready = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_ready;
    load_p1  = in_valid && in_ready;
    load_p2  = vld_p1_q && s2_ready;
    vld_p1_d = in_ready ? in_valid : vld_p1_q;
    vld_p2_d = s2_ready ? vld_p1_q : vld_p2_q;
    res_p2_d = pack_result(kind_p1_q, sign_p1_q, exp_p1_q, mag_p1_q, pass_p1_q);
  end

  // ---- S1: unpack, align / multiply ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (load_p1) begin
      kind_p1_q <= kind_d;
      sign_p1_q <= sign_d;
      exp_p1_q  <= exp_d;
      mag_p1_q  <= mag_d;
      pass_p1_q <= pass_d;
      tag_p1_q  <= tag;
    end
  end

  // ---- S2: normalise, truncate, pack, flags; drives the outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q   <= 1'b0;
      y_p2_q     <= '0;
      tag_p2_q   <= '0;
      flags_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      if (load_p2) begin
        y_p2_q     <= res_p2_d[W-1:0];
        flags_p2_q <= res_p2_d[W+2:W];
        tag_p2_q   <= tag_p1_q;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign y         = y_p2_q;
  assign out_tag   = tag_p2_q;
  assign out_flags = flags_p2_q;

endmodule

// File: tb/tb_float_alu_pipe.sv
// Directed bench for float_alu_pipe: e4m3 default instance plus a bf16 instance,
// covering latency, arithmetic corner cases, backpressure and mid-flight reset.
module tb_float_alu_pipe;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] MUL = 4'b0010;
  localparam logic [3:0] SUB = 4'b0011;
  localparam logic [3:0] MIN = 4'b0100;
  localparam logic [3:0] MAX = 4'b0101;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b, y;
  logic [3:0]  op, tag, out_tag;
  logic [2:0]  out_flags;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, y16;
  logic [3:0]  op16, tag16, out_tag16;
  logic [2:0]  out_flags16;

  int checks = 0;
  int errors = 0;

  int         ni, ne;
  bit         held, saw_block;
  logic [7:0] hy;
  logic [3:0] ht;
  logic [2:0] hf;

  float_alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_tag(out_tag), .out_flags(out_flags)
  );

  float_alu_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .tag(tag16), .out_valid(out_valid16),
    .out_ready(out_ready16), .y(y16), .out_tag(out_tag16), .out_flags(out_flags16)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit wide, input logic [3:0] o, input logic [15:0] va,
                        input logic [15:0] vb, input logic [3:0] t, input logic [15:0] wy,
                        input logic [2:0] wf, input string name);
    if (wide) begin
      in_valid16 = 1'b1; op16 = o; a16 = va; b16 = vb; tag16 = t;
    end else begin
      in_valid = 1'b1; op = o; a = va[7:0]; b = vb[7:0]; tag = t;
    end
    step();
    in_valid   = 1'b0;
    in_valid16 = 1'b0;
    chk({name, "_lat1"}, wide ? 32'(out_valid16) : 32'(out_valid), 32'd0);
    step();
    chk({name, "_vld"}, wide ? 32'(out_valid16) : 32'(out_valid), 32'd1);
    chk({name, "_y"}, wide ? 32'(y16) : 32'(y), 32'(wy));
    chk({name, "_tag"}, wide ? 32'(out_tag16) : 32'(out_tag), 32'(t));
    chk({name, "_flags"}, wide ? 32'(out_flags16) : 32'(out_flags), 32'(wf));
    step();
    chk({name, "_done"}, wide ? 32'(out_valid16) : 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; a = '0; b = '0; tag = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; tag16 = '0; out_ready16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_vld16", 32'(out_valid16), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    run_op(1'b0, ADD, 16'h38, 16'h38, 4'd3, 16'h40, 3'b000, "add_1p1");
    run_op(1'b0, MUL, 16'h3C, 16'h3C, 4'd4, 16'h41, 3'b000, "mul_1p5sq");
    run_op(1'b0, MUL, 16'h7F, 16'h40, 4'd5, 16'h7F, 3'b010, "mul_ovf");
    run_op(1'b0, MUL, 16'h08, 16'h08, 4'd6, 16'h00, 3'b001, "mul_unf");
    run_op(1'b0, SUB, 16'h38, 16'h38, 4'd7, 16'h00, 3'b000, "sub_zero");
    run_op(1'b0, MIN, 16'h38, 16'hB8, 4'd8, 16'hB8, 3'b000, "min_neg");
    run_op(1'b0, MAX, 16'h38, 16'hB8, 4'd9, 16'h38, 3'b000, "max_pos");
    run_op(1'b0, MIN, 16'h00, 16'h80, 4'd10, 16'h00, 3'b000, "min_zeros");
    run_op(1'b0, 4'b1111, 16'h38, 16'h38, 4'd11, 16'h00, 3'b100, "bad_op");
    run_op(1'b0, MUL, 16'h00, 16'hB8, 4'd12, 16'h80, 3'b000, "mul_negzero");
    run_op(1'b1, ADD, 16'h3F80, 16'h3F80, 4'd1, 16'h4000, 3'b000, "bf_add");
    run_op(1'b1, MUL, 16'h3FC0, 16'h3FC0, 4'd2, 16'h4010, 3'b000, "bf_mul");

    // Six max(0x30+i, 0) ops with the consumer stalled on cycles 3..7.
    ni = 0; ne = 0; held = 1'b0; saw_block = 1'b0;
    for (int cyc = 0; cyc < 40 && ne < 6; cyc++) begin
      in_valid  = (ni < 6);
      op        = MAX;
      a         = 8'h30 + 8'(ni);
      b         = 8'h00;
      tag       = 4'(ni);
      out_ready = !(cyc >= 3 && cyc <= 7);
      @(negedge clk);
      if (held) begin
        chk("stall_y", 32'(y), 32'(hy));
        chk("stall_tag", 32'(out_tag), 32'(ht));
        chk("stall_flags", 32'(out_flags), 32'(hf));
      end
      held = out_valid && !out_ready;
      hy = y; ht = out_tag; hf = out_flags;
      if (!in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        chk("strm_tag", 32'(out_tag), 32'(ne));
        chk("strm_y", 32'(y), 32'(8'h30 + 8'(ne)));
        chk("strm_flags", 32'(out_flags), 32'd0);
        ne++;
      end
      if (in_valid && in_ready) ni++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("strm_all_out", 32'(ne), 32'd6);
    chk("strm_all_in", 32'(ni), 32'd6);
    chk("strm_backpressure", 32'(saw_block), 32'd1);
    chk("strm_drained", 32'(out_valid), 32'd0);

    // Two ops in flight, then reset without a clock edge.
    out_ready = 1'b0;
    in_valid = 1'b1; op = ADD; a = 8'h38; b = 8'h38; tag = 4'd13;
    step();
    tag = 4'd14;
    step();
    in_valid = 1'b0;
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(out_valid), 32'd0);
    chk("midrst_tag", 32'(out_tag), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    run_op(1'b0, MUL, 16'h3C, 16'h3C, 4'd2, 16'h41, 3'b000, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
